// File: rtl/shared_delay_arbiter.sv
// shared_delay_arbiter: round-robin arbiter that shares one non-stalling
// DEPTH-stage delay line between two requesters. Each stage carries
// {valid, tag, data}; the last stage is steered to the owning channel.
// Per-channel credit counters cap the number of words in flight.
//
// Optional feature: define DLA_FLUSH_EN to add the `flush` input, which
// empties the line and clears both credit counters at the edge it is high.
//
// Handshake: in_i_ready is combinational and is only high when in_i_valid
// is high and channel i wins arbitration; a word is taken at a rising edge
// where valid && ready. Outputs have no backpressure: out_i_valid is high for
// exactly one cycle per word, and the word is gone after the next edge.
module shared_delay_arbiter #(
    parameter int WIDTH   = 3,
    parameter int DEPTH   = 4,
    parameter int CREDITS = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in0_valid,
    input  logic [WIDTH-1:0] in0_data,
    output logic             in0_ready,
    input  logic             in1_valid,
    input  logic [WIDTH-1:0] in1_data,
    output logic             in1_ready,
    output logic             out0_valid,
    output logic [WIDTH-1:0] out0_data,
    output logic             out1_valid,
    output logic [WIDTH-1:0] out1_data,
`ifdef DLA_FLUSH_EN
    input  logic             flush,
`endif
    output logic             busy
);

    localparam int CW = $clog2(CREDITS + 1);
    localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);

    // Delay line: index 0 is stage 1, index DEPTH-1 drives the outputs.
    logic [DEPTH-1:0] stg_valid;
    logic [DEPTH-1:0] stg_tag;
    logic [WIDTH-1:0] stg_data [DEPTH];

    logic [CW-1:0] cnt0;
    logic [CW-1:0] cnt1;
    logic          rr;

    logic flush_now;
    logic elig0;
    logic elig1;
    logic grant0;
    logic grant1;
    logic retire0;
    logic retire1;

`ifdef DLA_FLUSH_EN
    assign flush_now = flush;
`else
    assign flush_now = 1'b0;
`endif

    // Eligibility, round-robin grant and ready generation.
    always_comb begin
        elig0     = 1'b0;
        elig1     = 1'b0;
        grant0    = 1'b0;
        grant1    = 1'b0;
        in0_ready = 1'b0;
        in1_ready = 1'b0;
        elig0  = in0_valid && (cnt0 < CRED_MAX) && !flush_now;
        elig1  = in1_valid && (cnt1 < CRED_MAX) && !flush_now;
        grant0 = elig0 && (!elig1 || !rr);
        grant1 = elig1 && (!elig0 || rr);
        // Held low during reset so every output reads 0 while rst_n is low.
        in0_ready = grant0 && rst_n;
        in1_ready = grant1 && rst_n;
    end

    // Exit steering from the last stage.
    always_comb begin
        retire0    = stg_valid[DEPTH-1] && !stg_tag[DEPTH-1];
        retire1    = stg_valid[DEPTH-1] && stg_tag[DEPTH-1];
        out0_valid = retire0;
        out1_valid = retire1;
        out0_data  = retire0 ? stg_data[DEPTH-1] : '0;
        out1_data  = retire1 ? stg_data[DEPTH-1] : '0;
        busy       = |stg_valid;
    end

    // Delay line shift: stage 1 loads the granted word, others shift along.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_valid <= '0;
            stg_tag   <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                stg_data[k] <= '0;
            end
        end else begin
            stg_valid[0] <= grant0 | grant1;
            stg_tag[0]   <= grant1;
            stg_data[0]  <= grant0 ? in0_data : (grant1 ? in1_data : '0);
            for (int k = 1; k < DEPTH; k++) begin
                stg_valid[k] <= stg_valid[k-1];
                stg_tag[k]   <= stg_tag[k-1];
                stg_data[k]  <= stg_data[k-1];
            end
            if (flush_now) begin
                stg_valid <= '0;
            end
        end
    end

    // Credit counters: +1 on accept, -1 on retire, unchanged when both occur.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else if (flush_now) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (grant0 && !retire0) begin
                cnt0 <= cnt0 + 1'b1;
            end else if (!grant0 && retire0) begin
                cnt0 <= cnt0 - 1'b1;
            end
            if (grant1 && !retire1) begin
                cnt1 <= cnt1 + 1'b1;
            end else if (!grant1 && retire1) begin
                cnt1 <= cnt1 - 1'b1;
            end
        end
    end

    // Round-robin pointer: after a grant to channel i, favour the other one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr <= 1'b0;
        end else if (grant0) begin
            rr <= 1'b1;
        end else if (grant1) begin
            rr <= 1'b0;
        end
    end

endmodule
